rf_wb_arbiter: RTL

Controller in front of the integer register file write port. It arbitrates two write-back requesters onto the single write port: port 0 is EXU/ALU results and port 1 is LSU load data. Arbitration is round-robin with valid/ready handshakes, and the selected write is presented to the register file from a register stage. The block also keeps a per-register busy scoreboard, which the issue stage uses for RAW/WAW hazard detection.

---
 rtl/rf_wb_arbiter_pkg.sv | 24 ++
 rtl/defines.vh | 12 +
 rtl/rf_wb_arbiter_rr_arb2.sv | 50 +++++
 rtl/rf_wb_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Types and constants shared by the register-file write-back arbiter and its grant logic.
`include "defines.vh"

package rf_wb_arbiter_pkg;

    localparam int CPU_W     = `CPU_WIDTH;
    localparam int REG_AW    = `REG_ADDRW;
    localparam int REG_COUNT = `REG_COUNT;

    typedef enum logic {
        PORT_EXU = 1'(`WB_PORT_EXU),
        PORT_LSU = 1'(`WB_PORT_LSU)
    } wb_port_e;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [CPU_W-1:0]  data;
    } wb_req_t;

    function automatic logic addr_is_x0(input logic [REG_AW-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/defines.vh
// Shared core-wide widths and write-back port indices.
`ifndef RF_DEFINES_VH
`define RF_DEFINES_VH

`define CPU_WIDTH   32
`define REG_ADDRW   5
`define REG_COUNT   32

`define WB_PORT_EXU 0
`define WB_PORT_LSU 1

`endif

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester grant logic: round-robin, or fixed priority to the LSU when RR_EN=0.
// Grants depend only on the requests and the last-grant flop, never on downstream ready.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    wb_port_e last_grant_q;
    wb_port_e last_grant_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_gnt0       = 1'b0;
        o_gnt1       = 1'b0;
        last_grant_d = last_grant_q;
        if (i_req0 && i_req1) begin
            if (RR_EN && (last_grant_q == PORT_LSU)) begin
                o_gnt0 = 1'b1;
            end else begin
                o_gnt1 = 1'b1;
            end
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
        if (o_gnt0) begin
            last_grant_d = PORT_EXU;
        end else if (o_gnt1) begin
            last_grant_d = PORT_LSU;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_grant_q <= PORT_LSU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: arbitrates EXU/LSU write-backs into a registered
// write stage and keeps the per-register busy scoreboard used for issue hazard checks.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter bit RR_EN   = 1'b1,
    parameter int REG_CNT = REG_COUNT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_iss_valid,
    input  logic [REG_AW-1:0] i_iss_rd,
    output logic              o_iss_ready,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic              o_busy1,
    output logic              o_busy2,
    input  logic              i_wb0_valid,
    input  logic [REG_AW-1:0] i_wb0_addr,
    input  logic [CPU_W-1:0]  i_wb0_data,
    output logic              o_wb0_ready,
    input  logic              i_wb1_valid,
    input  logic [REG_AW-1:0] i_wb1_addr,
    input  logic [CPU_W-1:0]  i_wb1_data,
    output logic              o_wb1_ready,
    output logic              o_rf_wen,
    output logic [REG_AW-1:0] o_rf_waddr,
    output logic [CPU_W-1:0]  o_rf_wdata,
    output logic              o_err
);

    logic [REG_CNT-1:0] busy_q, busy_d;
    logic               rf_wen_q, rf_wen_d;
    logic [REG_AW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [CPU_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic               err_q, err_d;

    logic    gnt0, gnt1, any_gnt;
    wb_req_t sel;

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req0  (i_wb0_valid),
        .i_req1  (i_wb1_valid),
        .o_gnt0  (gnt0),
        .o_gnt1  (gnt1)
    );

    assign o_wb0_ready = gnt0;
    assign o_wb1_ready = gnt1;
    assign any_gnt     = gnt0 | gnt1;
    assign sel         = gnt1 ? wb_req_t'{addr: i_wb1_addr, data: i_wb1_data}
                              : wb_req_t'{addr: i_wb0_addr, data: i_wb0_data};

    // busy_q[0] is held at 0, so x0 always reads idle and never blocks issue.
    assign o_iss_ready = ~busy_q[i_iss_rd];
    assign o_busy1     = busy_q[i_raddr1];
    assign o_busy2     = busy_q[i_raddr2];

    always_comb begin
        busy_d = busy_q;
        if (rf_wen_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (i_iss_valid && o_iss_ready && !addr_is_x0(i_iss_rd)) begin
            busy_d[i_iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Writes to x0 still consume a grant but never reach the register file.
    always_comb begin
        rf_wen_d   = any_gnt && !addr_is_x0(sel.addr);
        rf_waddr_d = any_gnt ? sel.addr : rf_waddr_q;
        rf_wdata_d = any_gnt ? sel.data : rf_wdata_q;
        err_d      = err_q | (any_gnt && !addr_is_x0(sel.addr) && !busy_q[sel.addr]);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign o_rf_wen   = rf_wen_q;
    assign o_rf_waddr = rf_waddr_q;
    assign o_rf_wdata = rf_wdata_q;
    assign o_err      = err_q;

endmodule
